rv32_pc_stage: RTL and testbench

Program-counter generation stage directly upstream of the fetch stage. Owns the architectural fetch PC register and drives it onto the fetch stage `pc` input each cycle. Advances it sequentially, holds it on stall, and redirects it on branch/jump resolution. Also produces the flush request the fetch stage consumes as `set_nop`/`set_nop_pc`.

---
 rtl/rv32_pc_stage.sv | 113 +++++++++++
 tb/tb_rv32_pc_stage.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/rv32_pc_stage.sv
// Fetch PC generator: sequential advance, stall/hold, redirect with flush, optional BTB (RV32_PC_BTB_EN).
// Redirect takes effect on the next edge; predictions are looked up combinationally on the current pc.
module rv32_pc_stage #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          BTB_ENTRIES  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_stall,
  input  logic        hold,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        bp_update_valid,
  input  logic [31:0] bp_update_pc,
  input  logic [31:0] bp_update_target,
  input  logic        bp_update_taken,
  output logic [31:0] pc,
  output logic        predicted_taken,
  output logic        flush,
  output logic [31:0] flush_pc,
  output logic        misaligned_redirect,
  output logic [31:0] fetch_count
);

  logic        advance;
  logic [31:0] redirect_aligned;
  logic [31:0] pred_target;
  logic [31:0] pc_nxt;

  assign advance          = !fetch_stall && !hold && !redirect_valid;
  assign redirect_aligned = {redirect_pc[31:2], 2'b00};
  assign flush            = redirect_valid;
  assign flush_pc         = redirect_valid ? redirect_aligned : pc;

`ifdef RV32_PC_BTB_EN
  localparam int IDXW = $clog2(BTB_ENTRIES);
  localparam int TAGW = 30 - IDXW;

  logic            btb_vld [BTB_ENTRIES];
  logic [TAGW-1:0] btb_tag [BTB_ENTRIES];
  logic [29:0]     btb_tgt [BTB_ENTRIES];
  logic [1:0]      btb_ctr [BTB_ENTRIES];

  logic [IDXW-1:0] lk_idx;
  logic [TAGW-1:0] lk_tag;
  logic [IDXW-1:0] up_idx;
  logic [TAGW-1:0] up_tag;
  logic            up_hit;
  logic            unused_bp;

  assign lk_idx = pc[IDXW+1:2];
  assign lk_tag = pc[31:IDXW+2];
  assign up_idx = bp_update_pc[IDXW+1:2];
  assign up_tag = bp_update_pc[31:IDXW+2];
  assign up_hit = btb_vld[up_idx] && (btb_tag[up_idx] == up_tag);

  // Lookup reads the arrays before this edge's update lands, so same-cycle updates are not visible.
  assign predicted_taken = btb_vld[lk_idx] && (btb_tag[lk_idx] == lk_tag) && btb_ctr[lk_idx][1];
  assign pred_target     = {btb_tgt[lk_idx], 2'b00};
  assign unused_bp       = ^{bp_update_pc[1:0], bp_update_target[1:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < BTB_ENTRIES; i++) btb_vld[i] <= 1'b0;
    end else if (bp_update_valid && !up_hit && bp_update_taken) begin
      btb_vld[up_idx] <= 1'b1;
    end
  end

  // Payload fields need no reset; they are only trusted once the valid bit is set.
  always_ff @(posedge clk) begin
    if (bp_update_valid) begin
      if (!up_hit) begin
        if (bp_update_taken) begin
          btb_tag[up_idx] <= up_tag;
          btb_tgt[up_idx] <= bp_update_target[31:2];
          btb_ctr[up_idx] <= 2'b10;
        end
      end else if (bp_update_taken) begin
        btb_tgt[up_idx] <= bp_update_target[31:2];
        if (btb_ctr[up_idx] != 2'b11) btb_ctr[up_idx] <= btb_ctr[up_idx] + 2'd1;
      end else begin
        if (btb_ctr[up_idx] != 2'b00) btb_ctr[up_idx] <= btb_ctr[up_idx] - 2'd1;
      end
    end
  end
`else
  logic unused_bp;

  assign predicted_taken = 1'b0;
  assign pred_target     = 32'h0000_0000;
  assign unused_bp       = ^{bp_update_valid, bp_update_pc, bp_update_target, bp_update_taken};
`endif

  always_comb begin
    pc_nxt = pc;
    if (redirect_valid)            pc_nxt = redirect_aligned;
    else if (!fetch_stall && !hold) pc_nxt = predicted_taken ? pred_target : pc + 32'd4;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc                  <= RESET_VECTOR;
      misaligned_redirect <= 1'b0;
      fetch_count         <= 32'h0000_0000;
    end else begin
      pc                  <= pc_nxt;
      misaligned_redirect <= redirect_valid && (redirect_pc[1:0] != 2'b00);
      if (advance) fetch_count <= fetch_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_rv32_pc_stage.sv
// Directed bench for rv32_pc_stage with RESET_VECTOR = 32'h100; BTB cases run when RV32_PC_BTB_EN is defined.
module tb_rv32_pc_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_stall, hold, redirect_valid;
  logic [31:0] redirect_pc;
  logic        bp_update_valid, bp_update_taken;
  logic [31:0] bp_update_pc, bp_update_target;
  logic [31:0] pc, flush_pc, fetch_count;
  logic        predicted_taken, flush, misaligned_redirect;

  int total = 0;
  int bad   = 0;

  rv32_pc_stage #(.RESET_VECTOR(32'h0000_0100), .BTB_ENTRIES(16)) dut (
    .clk(clk), .reset(reset), .fetch_stall(fetch_stall), .hold(hold),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .bp_update_valid(bp_update_valid), .bp_update_pc(bp_update_pc),
    .bp_update_target(bp_update_target), .bp_update_taken(bp_update_taken),
    .pc(pc), .predicted_taken(predicted_taken), .flush(flush), .flush_pc(flush_pc),
    .misaligned_redirect(misaligned_redirect), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic redirect_to(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    tick();
    redirect_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; fetch_stall = 1'b0; hold = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    bp_update_valid = 1'b0; bp_update_taken = 1'b0; bp_update_pc = '0; bp_update_target = '0;
    tick();
    tick();
    chk("rst_pc", pc, 32'h100);
    chk("rst_cnt", fetch_count, 32'h0);
    chk("rst_flush", {31'b0, flush}, 32'h0);
    chk("rst_flush_pc", flush_pc, 32'h100);
    chk("rst_mis", {31'b0, misaligned_redirect}, 32'h0);
    chk("rst_pred", {31'b0, predicted_taken}, 32'h0);
    reset = 1'b0;

    // sequential advance
    tick(); chk("seq_104", pc, 32'h104);
    tick(); chk("seq_108", pc, 32'h108);
    chk("seq_cnt2", fetch_count, 32'h2);

    // fetch stall freezes pc and count
    fetch_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_pc", pc, 32'h108);
      chk("stall_cnt", fetch_count, 32'h2);
    end
    fetch_stall = 1'b0;
    tick(); chk("unstall_pc", pc, 32'h10C);
    chk("unstall_cnt", fetch_count, 32'h3);
    tick(); chk("seq_110", pc, 32'h110);
    chk("seq_cnt4", fetch_count, 32'h4);

    // misaligned redirect together with hold
    redirect_valid = 1'b1; redirect_pc = 32'h2002; hold = 1'b1;
    #1;
    chk("redir_flush", {31'b0, flush}, 32'h1);
    chk("redir_flush_pc", flush_pc, 32'h2000);
    tick();
    redirect_valid = 1'b0;
    chk("redir_pc", pc, 32'h2000);
    chk("redir_mis", {31'b0, misaligned_redirect}, 32'h1);
    chk("redir_cnt", fetch_count, 32'h4);
    chk("post_flush", {31'b0, flush}, 32'h0);
    chk("post_flush_pc", flush_pc, 32'h2000);
    tick();
    chk("hold_pc", pc, 32'h2000);
    chk("mis_pulse_end", {31'b0, misaligned_redirect}, 32'h0);
    chk("hold_cnt", fetch_count, 32'h4);
    hold = 1'b0;

    // aligned redirect to top of address space, then wrap
    redirect_to(32'hFFFF_FFFC);
    chk("top_pc", pc, 32'hFFFF_FFFC);
    chk("top_mis", {31'b0, misaligned_redirect}, 32'h0);
    tick();
    chk("wrap_pc", pc, 32'h0);
    chk("wrap_cnt", fetch_count, 32'h5);

`ifdef RV32_PC_BTB_EN
    // allocate entry for pc 40 -> 80, then walk into it
    do_reset();
    bp_update_valid = 1'b1; bp_update_pc = 32'h40; bp_update_target = 32'h80; bp_update_taken = 1'b1;
    tick();
    bp_update_valid = 1'b0;
    redirect_to(32'h38);
    chk("btb_38_pred", {31'b0, predicted_taken}, 32'h0);
    tick(); chk("btb_3c", pc, 32'h3C);
    tick(); chk("btb_40", pc, 32'h40);
    chk("btb_40_pred", {31'b0, predicted_taken}, 32'h1);
    tick(); chk("btb_jump_80", pc, 32'h80);
    // two not-taken updates drop counter from 10 to 00
    hold = 1'b1;
    bp_update_valid = 1'b1; bp_update_pc = 32'h40; bp_update_taken = 1'b0;
    tick();
    tick();
    bp_update_valid = 1'b0; hold = 1'b0;
    redirect_to(32'h40);
    chk("btb_nt_pred", {31'b0, predicted_taken}, 32'h0);
    tick(); chk("btb_nt_44", pc, 32'h44);

    // same-cycle update and lookup of pc 40 on a fresh BTB
    do_reset();
    redirect_to(32'h40);
    bp_update_valid = 1'b1; bp_update_pc = 32'h40; bp_update_target = 32'h200; bp_update_taken = 1'b1;
    #1;
    chk("same_cyc_pred", {31'b0, predicted_taken}, 32'h0);
    tick();
    bp_update_valid = 1'b0;
    chk("same_cyc_44", pc, 32'h44);
    redirect_to(32'h40);
    chk("revisit_pred", {31'b0, predicted_taken}, 32'h1);
    tick(); chk("revisit_200", pc, 32'h200);
`else
    // predictor absent: updates are ignored
    bp_update_valid = 1'b1; bp_update_pc = 32'h8; bp_update_target = 32'h80; bp_update_taken = 1'b1;
    tick();
    bp_update_valid = 1'b0;
    chk("nobtb_4", pc, 32'h4);
    tick();
    chk("nobtb_8", pc, 32'h8);
    chk("nobtb_pred", {31'b0, predicted_taken}, 32'h0);
    tick();
    chk("nobtb_c", pc, 32'hC);
    chk("nobtb_cnt", fetch_count, 32'h8);
`endif

    // asynchronous reset asserted mid-stall, away from any clock edge
    fetch_stall = 1'b1;
    tick();
    #3;
    reset = 1'b1;
    #1;
    chk("async_rst_pc", pc, 32'h100);
    chk("async_rst_cnt", fetch_count, 32'h0);
    chk("async_rst_mis", {31'b0, misaligned_redirect}, 32'h0);
    tick();
    reset = 1'b0;
    fetch_stall = 1'b0;
    tick();
    chk("post_rst_104", pc, 32'h104);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
